// File: rtl/pipe_pkg.sv
// Shared types and default bundle widths for the inter-stage pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int OCC_W = 2;

    // Default widths for each inter-stage bundle
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 3;
    localparam int EXMEM_DATA_W = 72;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 68;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register. clear drops the valid bit but keeps the
// payload so an emptied stage still shows its last data.
module pipe_slot #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 128
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            q_data  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_ctrl  <= d_ctrl;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and flush-to-bubble.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    pipe_state_e       state, state_n;
    logic              in_xfer, out_xfer;
    logic              m_load, m_clear, m_valid;
    logic [CTRL_W-1:0] m_ctrl, m_d_ctrl;
    logic [DATA_W-1:0] m_data, m_d_data;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_load, s_clear, s_valid, m_from_s;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    // Ready depends only on the state register, breaking the out_ready->in_ready path
    assign in_ready  = (state != TWO);
    assign m_d_ctrl  = m_from_s ? s_ctrl : in_ctrl;
    assign m_d_data  = m_from_s ? s_data : in_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot_s (
        .CLK     (CLK),
        .RST     (RST),
        .load    (s_load),
        .clear   (s_clear),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .q_valid (s_valid),
        .q_ctrl  (s_ctrl),
        .q_data  (s_data)
    );
`else
    assign in_ready  = !m_valid | out_ready;
    assign m_d_ctrl  = in_ctrl;
    assign m_d_data  = in_data;
    assign occupancy = {1'b0, m_valid};
`endif

    assign in_xfer   = in_valid & in_ready & !flush;
    assign out_xfer  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot_m (
        .CLK     (CLK),
        .RST     (RST),
        .load    (m_load),
        .clear   (m_clear),
        .d_ctrl  (m_d_ctrl),
        .d_data  (m_d_data),
        .q_valid (m_valid),
        .q_ctrl  (m_ctrl),
        .q_data  (m_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= EMPTY;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        m_load  = 1'b0;
        m_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        s_load   = 1'b0;
        s_clear  = 1'b0;
        m_from_s = 1'b0;
`endif
        if (flush) begin
            state_n = EMPTY;
            m_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            s_clear = 1'b1;
`endif
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    m_load  = 1'b1;
                    state_n = ONE;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_load = 1'b1;
                    end else if (in_xfer) begin
`ifdef PIPE_STAGE_SKID_EN
                        s_load  = 1'b1;
                        state_n = TWO;
`else
                        m_load  = 1'b1;
`endif
                    end else if (out_xfer) begin
                        m_clear = 1'b1;
                        state_n = EMPTY;
                    end
                end
                TWO: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (out_xfer) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        s_clear  = 1'b1;
                        state_n  = ONE;
                    end
`else
                    state_n = EMPTY;
`endif
                end
                default: state_n = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN if defined.
module tb_pipe_stage_reg;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 9;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [DATA_W-1:0] rx[$];
    int sent;

    initial begin
        // Reset values while RST is held low
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("rst_out_data",  out_data,        128'd0);
        chk("rst_occ",       128'(occupancy), 128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        RST = 1'b1;

        // Back-to-back stream, one-cycle latency
        out_ready = 1'b1;
        in_ctrl   = 9'h1A5;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(i);
            tick();
            chk("stream_data", out_data, 128'(i));
            chk("stream_occ",  128'(occupancy), 128'd1);
            if (i == 0) chk("stream_ctrl", 128'(out_ctrl), 128'h1A5);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 128'(out_valid), 128'd0);
        chk("drain_ctrl",  128'(out_ctrl),  128'd0);
        chk("drain_occ",   128'(occupancy), 128'd0);
        chk("drain_hold",  out_data,        128'd9);

        // Stall
        in_ctrl   = 9'h0F3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h11;
        tick();
        chk("stall_head", out_data, 128'h11);
        chk("stall_valid", 128'(out_valid), 128'd1);
        in_data = 128'h22;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("stall_rdy1", 128'(in_ready), 128'd1);
        tick();
        chk("stall_occ2", 128'(occupancy), 128'd2);
        chk("stall_rdy0", 128'(in_ready),  128'd0);
        chk("stall_hold", out_data,        128'h11);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_2nd", out_data, 128'h22);
        chk("release_occ", 128'(occupancy), 128'd1);
        tick();
        chk("release_empty", 128'(occupancy), 128'd0);
`else
        chk("stall_rdy0", 128'(in_ready), 128'd0);
        tick();
        chk("stall_hold", out_data, 128'h11);
        chk("stall_occ",  128'(occupancy), 128'd1);
        out_ready = 1'b1;
        #1;
        chk("release_rdy", 128'(in_ready), 128'd1);
        tick();
        chk("release_2nd", out_data, 128'h22);
        in_valid = 1'b0;
        tick();
        chk("release_empty", 128'(occupancy), 128'd0);
`endif

        // Flush while full, with a new entry offered in the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h44;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 128'h55;
        tick();
        chk("full_occ", 128'(occupancy), 128'd2);
`endif
        in_data = 128'h33;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 128'(out_valid), 128'd0);
        chk("flush_ctrl",  128'(out_ctrl),  128'd0);
        chk("flush_occ",   128'(occupancy), 128'd0);
        chk("flush_rdy",   128'(in_ready),  128'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no33", 128'(out_valid), 128'd0);
        end

        // Flush in the same cycle as an output transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h66;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 128'h77;
        tick();
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        chk("fx_head", out_data, 128'h66);
        tick();
        flush = 1'b0;
        chk("fx_valid", 128'(out_valid), 128'd0);
        chk("fx_occ",   128'(occupancy), 128'd0);
        chk("fx_hold",  out_data,        128'h66);
        tick();
        chk("fx_nodup", 128'(out_valid), 128'd0);

        // Asynchronous reset between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h88;
        tick();
        chk("ar_pre", out_data, 128'h88);
        #2;
        RST = 1'b0;
        #1;
        chk("ar_valid", 128'(out_valid), 128'd0);
        chk("ar_data",  out_data,        128'd0);
        chk("ar_ctrl",  128'(out_ctrl),  128'd0);
        chk("ar_occ",   128'(occupancy), 128'd0);
        in_valid = 1'b0;
        tick();
        RST       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 128'h99;
        out_ready = 1'b1;
        tick();
        chk("ar_new_data",  out_data,        128'h99);
        chk("ar_new_valid", 128'(out_valid), 128'd1);
        chk("ar_new_occ",   128'(occupancy), 128'd1);
        in_valid = 1'b0;
        tick();

        // out_ready toggling 1010 under continuous offer; nothing lost or reordered
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c % 2 == 0);
            in_valid  = 1'b1;
            in_data   = 128'h100 + 128'(sent);
            #1;
`ifndef PIPE_STAGE_SKID_EN
            chk("tog_ready", 128'(in_ready), 128'(!out_valid | out_ready));
`endif
            if (out_valid && out_ready) rx.push_back(out_data);
            if (in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid && out_ready) rx.push_back(out_data);
            tick();
        end
        chk("tog_count", 128'(rx.size()), 128'(sent));
        chk("tog_some",  128'(sent > 5),  128'd1);
        for (int k = 0; k < rx.size(); k++)
            chk("tog_order", rx[k], 128'h100 + 128'(k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
